// File: rtl/oh_skid_buffer_if.sv
// +----------------------------------------------------------------------+
// | Module   : oh_skid_buffer_if                                         |
// | Brief    : valid/ready/data stream bundle with producer/consumer     |
// |            views, used on both sides of the skid buffer.             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

interface oh_skid_buffer_if #(
    parameter int N = 1
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    // master drives a beat, slave accepts it
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/oh_skid_buffer.sv
// +----------------------------------------------------------------------+
// | Module   : oh_skid_buffer                                            |
// | Brief    : two-entry registered valid/ready elastic buffer; every    |
// |            output comes straight from a flop.                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module oh_skid_buffer #(
    parameter int N          = 1,
    parameter     RESET_DATA = "TRUE"
) (
    input  wire logic         clk,
    input  wire logic         reset,
    oh_skid_buffer_if.slave   in_s,
    oh_skid_buffer_if.master  out_m,
    output logic              full
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         full_q, full_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic [N-1:0] skid_q, skid_d;

    logic         w_in_xfer;
    logic         w_out_xfer;

    assign w_in_xfer  = in_s.valid & in_ready_q;
    assign w_out_xfer = out_valid_q & out_m.ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (w_in_xfer) begin
                    state_d    = BUSY;
                    out_data_d = in_s.data;
                end
            end
            BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    out_data_d = in_s.data;
                end else if (w_in_xfer) begin
                    state_d = FULL;
                    skid_d  = in_s.data;
                end else if (w_out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    state_d    = BUSY;
                    out_data_d = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // status flags are decoded from the next state so they can be flopped
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        full_d      = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
        end
    end

    generate
        if (RESET_DATA == "TRUE") begin : g_reset_data
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_data_q <= '0;
                    skid_q     <= '0;
                end else begin
                    out_data_q <= out_data_d;
                    skid_q     <= skid_d;
                end
            end
        end else begin : g_no_reset_data
            always_ff @(posedge clk) begin
                out_data_q <= out_data_d;
                skid_q     <= skid_d;
            end
        end
    endgenerate

    assign in_s.ready  = in_ready_q;
    assign out_m.valid = out_valid_q;
    assign out_m.data  = out_data_q;
    assign full        = full_q;

endmodule

`default_nettype wire

// File: doc/oh_skid_buffer.md
Name: oh_skid_buffer

Overview:
- Registered valid/ready elastic buffer for an N-bit data path, with two entries (main + skid).
- Data flows forward; backpressure (ready) flows in the reverse direction through a register, which breaks the combinational ready path between producer and consumer.
- Sustains one transfer per cycle with 1-cycle forward latency.
- Used to retime long or high-fanout stream interfaces across stdlib blocks.

Parameters:
- N, 1, data vector width in bits.
- RESET_DATA, "TRUE", "TRUE": data registers are cleared on reset. "FALSE": data registers are not reset; only control state is reset.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  producer has data on in_data.
- in_data  input  N  producer data.
- in_ready  output  1  buffer can accept data; driven directly from a flop.
- out_valid  output  1  out_data is valid; driven directly from a flop.
- out_data  output  N  data to consumer; driven directly from a flop.
- out_ready  input  1  consumer accepts out_data.
- full  output  1  both entries occupied (state FULL); driven directly from a flop.

Behaviour:
- Interface: one clock domain; synchronous active-high reset `reset` on clock `clk`.
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Both are sampled at the rising edge of clk.
- Reset (reset=1 at an edge):
  - state=EMPTY, in_ready=0, out_valid=0, full=0.
  - out_data=0 and skid=0 if RESET_DATA="TRUE".
  - in_ready rises to 1 at the first edge with reset=0.
  - Reset overrides any transfer in the same cycle; buffered data is discarded.
- States:
  - EMPTY: out_valid=0, full=0.
  - BUSY: one entry, held in out_data; out_valid=1.
  - FULL: two entries, out_data plus skid; out_valid=1, full=1, in_ready=0.
- Transitions (next-state values are registered):
  - EMPTY, in_xfer -> BUSY; out_data<=in_data.
  - EMPTY, no in_xfer -> EMPTY.
  - BUSY, in_xfer & out_xfer -> BUSY; out_data<=in_data.
  - BUSY, in_xfer & !out_xfer -> FULL; skid<=in_data; in_ready<=0.
  - BUSY, !in_xfer & out_xfer -> EMPTY.
  - BUSY, neither -> BUSY.
  - FULL, out_xfer -> BUSY; out_data<=skid; in_ready<=1.
  - FULL, no out_xfer -> FULL.
  - in_xfer cannot occur in FULL because in_ready=0.
- Combinational paths: in_ready is next_state!=FULL, registered. There is no combinational path from out_ready to in_ready, or from in_* to out_*.
- Latency and throughput:
  - First beat appears on out_* one cycle after in_xfer.
  - Sustained 1 beat/cycle while out_ready=1.
  - Ordering is strict FIFO; no beat is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_valid and out_data hold unchanged.
- Producer side: in_valid may be asserted independently of in_ready. The block tolerates in_valid toggling and in_data changing while in_ready=0, and does not capture in that case.
- X handling: in_data is never captured unless in_xfer=1. With RESET_DATA="FALSE", out_data is don't-care while out_valid=0.
- Width: all data paths are exactly N bits; no padding or truncation. N=1 must be supported.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1, in_data=0xA5 (N=8) -> in_ready=0, out_valid=0, full=0, out_data=0 throughout; in_ready=1 one edge after release; nothing captured.
- Single beat: in 0x3C for one cycle with out_ready=1 -> out_valid=1 and out_data=0x3C on the next cycle only; state returns to EMPTY.
- Streaming: in_valid=1 with 0x00..0x0F over 16 consecutive cycles, out_ready=1 -> out_data is 0x00..0x0F on 16 consecutive cycles, starting 1 cycle later; in_ready stays 1.
- Backpressure fill and drain: out_ready=0, send 0x11 and 0x22 -> full=1, in_ready=0 after the 2nd beat; 0x33 is held off while out_data stays 0x11. Then out_ready=1 -> 0x11, 0x22, 0x33 delivered in order; in_ready returns 1 one cycle after the first out_xfer.
- Random stress: random in_valid and out_ready at 50% for 10k cycles -> scoreboard shows in-order delivery with no loss or duplication; out_data stable whenever out_valid & !out_ready; no beat accepted while in_ready=0.
- Reset mid-operation: reach FULL with 0x44 and 0x55, then assert reset for 1 cycle -> out_valid=0, full=0; the next beat 0x66 emerges as the first output; 0x44 and 0x55 never appear.
